count_tracker: RTL and testbench
================================

Name: count_tracker

Overview:
- Receive-side companion of the 4-bit up/down counter: samples the counter's dout stream and recovers direction.
- Locks onto a consistent stepping pattern, then flags wraps, reversals, restarts and illegal jumps as registered pulses.
- Sits beside the counter, or downstream of any counter-driven bus, as a synthesizable run-time checker and event source.

Parameters:
- W, 4, width of sampled count.
- LOCK_CNT, 2, consecutive same-direction ±1 steps required to enter LOCK (range 1..15).
- ERR_CNT_W, 8, width of saturating error counter.
- MAX_STALL, 3, repeats tolerated in LOCK (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  W  sampled count value.
- din_vld  in  1  din is valid this cycle.
- locked  out  1  tracker is in LOCK.
- dir  out  1  recovered direction, 1=up, 0=down; meaningful while locked.
- wrap  out  1  one-cycle pulse on modular wrap (up max->0, down 0->max).
- rev  out  1  one-cycle pulse on legal direction reversal in LOCK.
- restart  out  1  one-cycle pulse when a counter reset (jump to 0) is detected.
- err  out  1  one-cycle pulse on illegal step.
- err_cnt  out  ERR_CNT_W  saturating count of err pulses.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; prev=0; run=0.
  - All outputs 0.
- Registers update only on clk edges with din_vld=1. With din_vld=0 all state holds and all pulses are 0.
- Latency: every output reflects the sample taken one edge earlier. Pulses last exactly one cycle.
- Step class, computed as delta = (din - prev) mod 2^W:
  - delta==1 -> UP.
  - delta==2^W-1 -> DOWN.
  - delta==0 -> HOLD.
  - else -> JUMP.
- prev<=din on every valid sample in every state.
- IDLE: first valid sample -> ACQ, run=0.
- ACQ:
  - UP/DOWN matching the candidate direction -> run+1.
  - UP/DOWN with a different candidate -> candidate:=new direction, run=1.
  - HOLD -> no change.
  - JUMP -> run=0; if din==0, pulse restart.
  - When run reaches LOCK_CNT: go to LOCK, dir:=candidate, locked=1 from the next cycle.
- LOCK:
  - Step in the same direction as dir -> ok.
  - Wrap check: if prev==2^W-1 and din==0 while up, or prev==0 and din==2^W-1 while down, also pulse wrap.
  - Step opposite to dir -> dir flips, pulse rev, stay in LOCK.
  - HOLD -> legal, stay in LOCK.
  - JUMP with din==0 -> pulse restart, go to ACQ, run=0, no err.
  - JUMP with din!=0 -> pulse err, err_cnt+1 (saturates at all-ones), go to ACQ, run=0.
- Simultaneous events: restart and err are mutually exclusive. wrap and rev never coincide. Reversal across a wrap boundary (e.g. prev=0 up, din=15) pulses rev only.
- Reset mid-operation: everything returns to the reset values immediately, including err_cnt.
- No priority between din_vld and reset; reset dominates.

Optional Feature:
- Macro: COUNT_TRACKER_STALL_CHK_EN.
- Defined:
  - LOCK keeps a stall counter, cleared on any non-HOLD step.
  - A HOLD that makes the consecutive-HOLD count exceed MAX_STALL pulses err, increments err_cnt and returns to ACQ.
  - IDLE/ACQ are unaffected.
- Undefined: HOLD is always legal, no stall counter logic exists, and MAX_STALL is ignored.

Decomposition:
- Package count_track_pkg:
  - State enum (IDLE, ACQ, LOCK).
  - Step-class enum (UP, DOWN, HOLD, JUMP).
  - Direction constants DIR_UP=1, DIR_DOWN=0.
- Sub-module count_step_cls: purely combinational classifier. Inputs prev, din; output the step class. Parameterized by W.

Test Plan:
- Up lock: reset released, din_vld=1, din=3,4,5 -> locked=1 and dir=1 on the edge after din=5; err=0 throughout.
- Wrap up: locked up, din=14,15,0 -> wrap pulses one cycle after din=0; locked stays 1.
- Reversal: locked up at 7, then din=6,5 -> rev pulses once after 6, dir=0, locked stays 1; down wrap 1,0,15 -> wrap pulses.
- Restart vs error, from locked up at 9:
  - din=0 -> restart pulses, locked=0, err_cnt unchanged.
  - Relock, then din=12 after 5 -> err pulses, err_cnt increments by 1, locked=0.
- Saturation and reset: force 300 JUMPs with ERR_CNT_W=8 -> err_cnt=255. Then assert rst_n=0 mid-stream -> all outputs 0 asynchronously, before the next clk edge.
- Stall (with COUNT_TRACKER_STALL_CHK_EN, MAX_STALL=3): locked at 4, din=4 repeated 4 times -> err pulses on the 4th repeat. Without the macro -> no err.

Source files
------------

// File: rtl/count_track_pkg.sv
// Shared types for the count tracker: FSM states, step classes, direction codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package count_track_pkg;

  // Tracker FSM states
  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK
  } state_t;

  // Classification of one sample-to-sample step
  typedef enum logic [1:0] {
    UP,
    DOWN,
    HOLD,
    JUMP
  } step_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Run counter width; LOCK_CNT is limited to 1..15
  localparam int RUN_W = 4;

endpackage

// File: rtl/count_step_cls.sv
// Classifies the step between the previous and current sample as UP/DOWN/HOLD/JUMP.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumers qualify with din_vld.
module count_step_cls
  import count_track_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] prev,
  input  logic [W-1:0] din,
  output step_t        cls
);

  logic [W-1:0] delta;

  // Modular difference decides the class; anything but 0/+1/-1 is a jump
  always_comb begin
    delta = din - prev;
    cls   = JUMP;
    if (delta == W'(1)) begin
      cls = UP;
    end else if (delta == '1) begin
      cls = DOWN;
    end else if (delta == '0) begin
      cls = HOLD;
    end
  end

endmodule

// File: rtl/count_tracker.sv
// Recovers counter direction from a sampled count stream and flags wrap/rev/restart/err.
// Latency: every output reflects the sample taken one edge earlier; pulses last one cycle.
// Backpressure: none; din_vld=0 freezes state and zeroes pulses. Optional stall check: COUNT_TRACKER_STALL_CHK_EN.
module count_tracker
  import count_track_pkg::*;
#(
  parameter int W         = 4,
  parameter int LOCK_CNT  = 2,
  parameter int ERR_CNT_W = 8,
  parameter int MAX_STALL = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_vld,
  output logic                 locked,
  output logic                 dir,
  output logic                 wrap,
  output logic                 rev,
  output logic                 restart,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [RUN_W-1:0]     LOCK_RUN = RUN_W'(LOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t           state;
  logic [W-1:0]     prev;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic             cand;
  step_t            cls;
  logic             step_dir;
  logic             stall_hit;

  count_step_cls #(.W(W)) u_step_cls (
    .prev (prev),
    .din  (din),
    .cls  (cls)
  );

  // Direction of a +/-1 step and the run length it would produce during acquisition
  always_comb begin
    step_dir = (cls == UP) ? DIR_UP : DIR_DOWN;
    run_nxt  = ((run != '0) && (step_dir == cand)) ? run + 1'b1 : RUN_W'(1);
  end

`ifdef COUNT_TRACKER_STALL_CHK_EN
  localparam int STALL_W = $clog2(MAX_STALL + 2);

  logic [STALL_W-1:0] stall;

  // A HOLD in LOCK that would push the repeat count past MAX_STALL is an error
  assign stall_hit = (state == LOCK) && (cls == HOLD) && (stall >= STALL_W'(MAX_STALL));

  // Count consecutive HOLDs in LOCK; any other valid sample clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall <= '0;
    end else if (din_vld) begin
      if ((state == LOCK) && (cls == HOLD) && !stall_hit) begin
        stall <= stall + 1'b1;
      end else begin
        stall <= '0;
      end
    end
  end
`else
  // Stall checking compiled out: HOLD is always legal and MAX_STALL has no effect
  assign stall_hit = (MAX_STALL < 0);
`endif

  // Tracker FSM with registered outputs; pulses default low every edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      run     <= '0;
      cand    <= DIR_DOWN;
      locked  <= 1'b0;
      dir     <= DIR_DOWN;
      wrap    <= 1'b0;
      rev     <= 1'b0;
      restart <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      wrap    <= 1'b0;
      rev     <= 1'b0;
      restart <= 1'b0;
      err     <= 1'b0;
      if (din_vld) begin
        prev <= din;
        case (state)
          IDLE: begin
            state <= ACQ;
            run   <= '0;
          end
          ACQ: begin
            case (cls)
              UP, DOWN: begin
                cand <= step_dir;
                if (run_nxt >= LOCK_RUN) begin
                  state  <= LOCK;
                  locked <= 1'b1;
                  dir    <= step_dir;
                  run    <= '0;
                end else begin
                  run <= run_nxt;
                end
              end
              HOLD: begin
              end
              JUMP: begin
                run <= '0;
                if (din == '0) restart <= 1'b1;
              end
              default: begin
              end
            endcase
          end
          LOCK: begin
            case (cls)
              UP, DOWN: begin
                if (step_dir == dir) begin
                  // Same-direction step across the modular boundary
                  wrap <= (step_dir == DIR_UP) ? (prev == '1) : (prev == '0);
                end else begin
                  dir <= step_dir;
                  rev <= 1'b1;
                end
              end
              HOLD: begin
                if (stall_hit) begin
                  err    <= 1'b1;
                  state  <= ACQ;
                  locked <= 1'b0;
                  run    <= '0;
                  if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                end
              end
              JUMP: begin
                state  <= ACQ;
                locked <= 1'b0;
                run    <= '0;
                if (din == '0) begin
                  restart <= 1'b1;
                end else begin
                  err <= 1'b1;
                  if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
                end
              end
              default: begin
              end
            endcase
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_tracker.sv
// Self-checking bench for count_tracker: directed scenarios plus a random walk against a reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: din_vld=0 cycles are mixed in and must freeze state.
module tb_count_tracker;

  localparam int W         = 4;
  localparam int LOCK_CNT  = 2;
  localparam int ERR_CNT_W = 8;
  localparam int MAX_STALL = 3;
  localparam int MOD       = 1 << W;
  localparam int ERR_SAT   = (1 << ERR_CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [W-1:0]         din = '0;
  logic                 din_vld = 1'b0;
  logic                 locked, dir, wrap, rev, restart, err;
  logic [ERR_CNT_W-1:0] err_cnt;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state (integers and flags, derived from the stepping rules)
  bit m_seen, m_locked, m_cand, m_dir;
  int m_prev, m_run, m_stall, m_errs;
  bit e_wrap, e_rev, e_restart, e_err;

  always #5 clk = ~clk;

  count_tracker #(
    .W(W), .LOCK_CNT(LOCK_CNT), .ERR_CNT_W(ERR_CNT_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .locked(locked), .dir(dir), .wrap(wrap), .rev(rev),
    .restart(restart), .err(err), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_locked = 0; m_cand = 0; m_dir = 0;
    m_prev = 0; m_run = 0; m_stall = 0; m_errs = 0;
    e_wrap = 0; e_rev = 0; e_restart = 0; e_err = 0;
  endtask

  task automatic count_err();
    e_err = 1;
    if (m_errs < ERR_SAT) m_errs++;
  endtask

  task automatic model_sample(input int v);
    int d;
    bit up, pm1;
    d   = (v - m_prev + MOD) % MOD;
    up  = (d == 1);
    pm1 = (d == 1) || (d == MOD - 1);
    if (!m_seen) begin
      m_seen = 1;
      m_run  = 0;
    end else if (!m_locked) begin
      if (pm1) begin
        if (m_run > 0 && up == m_cand) m_run++;
        else m_run = 1;
        m_cand = up;
        if (m_run >= LOCK_CNT) begin
          m_locked = 1; m_dir = up; m_run = 0; m_stall = 0;
        end
      end else if (d != 0) begin
        m_run = 0;
        if (v == 0) e_restart = 1;
      end
    end else begin
      if (pm1) begin
        m_stall = 0;
        if (up == m_dir) e_wrap = up ? (m_prev == MOD - 1 && v == 0) : (m_prev == 0 && v == MOD - 1);
        else begin m_dir = up; e_rev = 1; end
      end else if (d == 0) begin
        m_stall++;
`ifdef COUNT_TRACKER_STALL_CHK_EN
        if (m_stall > MAX_STALL) begin
          count_err(); m_locked = 0; m_run = 0; m_stall = 0;
        end
`endif
      end else begin
        m_locked = 0; m_run = 0; m_stall = 0;
        if (v == 0) e_restart = 1;
        else count_err();
      end
    end
    m_prev = v;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked"},  locked,  m_locked);
    if (m_locked) check({tag, ".dir"}, dir, m_dir);
    check({tag, ".wrap"},    wrap,    e_wrap);
    check({tag, ".rev"},     rev,     e_rev);
    check({tag, ".restart"}, restart, e_restart);
    check({tag, ".err"},     err,     e_err);
    check({tag, ".err_cnt"}, err_cnt, m_errs);
  endtask

  task automatic step(input string tag, input int v, input bit vld);
    @(negedge clk);
    din     = W'(v);
    din_vld = vld;
    @(posedge clk);
    #1;
    e_wrap = 0; e_rev = 0; e_restart = 0; e_err = 0;
    if (vld) model_sample(v);
    check_all(tag);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din_vld = 1'b0;
    #1;
    model_reset();
    check_all("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c, wdir, r;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Up lock on 3,4,5
    step("up_lock", 3, 1);
    step("up_lock", 4, 1);
    step("up_lock", 5, 1);
    for (int v = 6; v < MOD; v++) step("count_up", v, 1);
    step("wrap_up", 0, 1);
    step("vld_low", 9, 0);
    step("vld_low", 9, 0);

    // Reversal at 7, then down wrap
    for (int v = 1; v <= 7; v++) step("to_seven", v, 1);
    step("rev", 6, 1);
    step("rev_follow", 5, 1);
    for (int v = 4; v >= 0; v--) step("count_down", v, 1);
    step("wrap_dn", MOD - 1, 1);

    // Restart vs error from a lock around 9
    step("reacq", 7, 1);
    step("reacq", 8, 1);
    step("reacq", 9, 1);
    step("restart", 0, 1);
    for (int v = 1; v <= 5; v++) step("relock", v, 1);
    step("jump_err", 12, 1);

    // Random walk with holds, reversals, jumps and idle cycles
    c = 12; wdir = 1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 11);
      if (r <= 5) begin
        c = (c + wdir + MOD) % MOD; step("rand", c, 1);
      end else if (r == 6) begin
        step("rand_hold", c, 1);
      end else if (r == 7) begin
        wdir = -wdir; c = (c + wdir + MOD) % MOD; step("rand_rev", c, 1);
      end else if (r == 8) begin
        c = $urandom_range(0, MOD - 1); step("rand_jump", c, 1);
      end else if (r == 9) begin
        c = 0; step("rand_zero", c, 1);
      end else begin
        step("rand_idle", $urandom_range(0, MOD - 1), 0);
      end
    end

    // Error counter saturation: lock then jump, repeatedly
    sync_reset();
    step("sat", 1, 1);
    for (int i = 0; i < 150; i++) begin
      step("sat", 2, 1);
      step("sat", 3, 1);
      step("sat", 9, 1);
      step("sat", 10, 1);
      step("sat", 11, 1);
      step("sat", 1, 1);
    end
    check("sat_final", err_cnt, ERR_SAT);

    // Asynchronous reset well before the next rising edge
    step("pre_async", 2, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Stall: lock at 4 then repeat 4 four times
    step("stall_lock", 2, 1);
    step("stall_lock", 3, 1);
    step("stall_lock", 4, 1);
    for (int i = 0; i < 4; i++) step("stall", 4, 1);
    step("stall_after", 5, 1);
    step("stall_after", 6, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
